// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - one-hot instruction phase sequencer with stall, restart and retire counter
//
// Purpose:
//   Generates one-hot phase strobes for each instruction. Instruction length
//   is set per cycle by last_phase (clamped to NUM_PHASES-1). Supports stall,
//   abort/restart and counts retired instructions. All outputs registered.
//
// Optional feature macro: CPU_PHASE_SINGLE_STEP_EN
//   Adds step_mode/step inputs and a STEP_WAIT state. With step_mode=1 the
//   sequencer parks after every completed instruction until step is pulsed.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   run          in   level, keep sequencing instructions
//   stall        in   level, hold current phase while ACTIVE
//   restart      in   pulse, abort current instruction, back to phase 0
//   last_phase   in   [CNT_W] index of final phase of current instruction
//   step_mode    in   (macro only) level, single-step enable
//   step         in   (macro only) pulse, release one instruction
//   phase        out  [NUM_PHASES] one-hot phase strobe, bit 0 = first phase
//   phase_idx    out  [CNT_W] binary index of active phase
//   active       out  high while ACTIVE
//   instr_done   out  one-cycle pulse after normal completion
//   instr_count  out  [CNT_INSTR_W] retired-instruction count (wraps)

module cpu_phase_sequencer #(
  parameter int NUM_PHASES  = 12,
  parameter int CNT_W       = 4,
  parameter int CNT_INSTR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   stall,
  input  logic                   restart,
  input  logic [CNT_W-1:0]       last_phase,
`ifdef CPU_PHASE_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output logic [NUM_PHASES-1:0]  phase,
  output logic [CNT_W-1:0]       phase_idx,
  output logic                   active,
  output logic                   instr_done,
  output logic [CNT_INSTR_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0]      MAX_IDX   = CNT_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

`ifdef CPU_PHASE_SINGLE_STEP_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, STEP_WAIT} state_t;
`else
  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] eff_last;
  logic             is_final;

  // last_phase is live: lowering it below the current index ends the
  // instruction at the next non-stalled cycle.
  always_comb begin
    eff_last = (last_phase > MAX_IDX) ? MAX_IDX : last_phase;
    is_final = (phase_idx >= eff_last);
  end

  always_ff @(posedge clk) begin
    instr_done <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      phase_idx   <= '0;
      active      <= 1'b0;
      instr_count <= '0;
    end else if (restart) begin
      // Abort: no completion pulse, no count.
      phase_idx <= '0;
      if (run) begin
        state  <= ACTIVE;
        phase  <= PHASE_ONE;
        active <= 1'b1;
      end else begin
        state  <= IDLE;
        phase  <= '0;
        active <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state     <= ACTIVE;
            phase     <= PHASE_ONE;
            phase_idx <= '0;
            active    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (stall) begin
            // hold everything, including the final phase
          end else if (is_final) begin
            instr_done  <= 1'b1;
            instr_count <= instr_count + 1'b1;
            phase_idx   <= '0;
`ifdef CPU_PHASE_SINGLE_STEP_EN
            if (step_mode) begin
              state  <= STEP_WAIT;
              phase  <= '0;
              active <= 1'b0;
            end else
`endif
            if (run) begin
              // back-to-back instruction, no bubble
              phase <= PHASE_ONE;
            end else begin
              state  <= IDLE;
              phase  <= '0;
              active <= 1'b0;
            end
          end else begin
            phase_idx <= phase_idx + 1'b1;
            phase     <= {phase[NUM_PHASES-2:0], 1'b0};
          end
        end
`ifdef CPU_PHASE_SINGLE_STEP_EN
        STEP_WAIT: begin
          if (step || (!step_mode && run)) begin
            state     <= ACTIVE;
            phase     <= PHASE_ONE;
            phase_idx <= '0;
            active    <= 1'b1;
          end else if (!step_mode) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          phase  <= '0;
          active <= 1'b0;
        end
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - directed self-checking bench for cpu_phase_sequencer

module tb_cpu_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, stall, restart;
  logic [3:0]  last_phase;
  logic [11:0] phase;
  logic [3:0]  phase_idx;
  logic        active, instr_done;
  logic [31:0] instr_count;

  // small instance: 4 phases, 3-bit counter for wrap coverage
  logic        run_w;
  logic [1:0]  last_w;
  logic [3:0]  phase_w;
  logic [1:0]  idx_w;
  logic        active_w, done_w;
  logic [2:0]  count_w;

  int total = 0;
  int bad   = 0;
  int pulses;

  cpu_phase_sequencer #(.NUM_PHASES(12), .CNT_W(4), .CNT_INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .restart(restart),
    .last_phase(last_phase), .phase(phase), .phase_idx(phase_idx),
    .active(active), .instr_done(instr_done), .instr_count(instr_count)
  );

  cpu_phase_sequencer #(.NUM_PHASES(4), .CNT_W(2), .CNT_INSTR_W(3)) dut_w (
    .clk(clk), .reset(reset), .run(run_w), .stall(1'b0), .restart(1'b0),
    .last_phase(last_w), .phase(phase_w), .phase_idx(idx_w),
    .active(active_w), .instr_done(done_w), .instr_count(count_w)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0; restart = 1'b0; last_phase = 4'd11;
    run_w = 1'b0; last_w = 2'd0;
    tick(2);
    reset = 1'b0;
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_idx", 32'(phase_idx), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_done", 32'(instr_done), 32'h0);
    check("rst_count", instr_count, 32'h0);

    // full 12-phase instruction
    run = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      check("walk_phase", 32'(phase), 32'h1 << k);
      check("walk_idx", 32'(phase_idx), 32'(k));
      check("walk_done", 32'(instr_done), 32'h0);
      tick();
    end
    check("wrap_phase", 32'(phase), 32'h001);
    check("wrap_done", 32'(instr_done), 32'h1);
    check("wrap_count", instr_count, 32'd1);

    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (instr_done) pulses++;
    end
    check("pulse_rate", 32'(pulses), 32'd2);
    check("count3", instr_count, 32'd3);

    // six-phase instructions
    last_phase = 4'd5;
    tick(5);
    check("lp5_top", 32'(phase), 32'h020);
    check("lp5_nodone", 32'(instr_done), 32'h0);
    tick();
    check("lp5_wrap", 32'(phase), 32'h001);
    check("lp5_done", 32'(instr_done), 32'h1);
    check("lp5_count", instr_count, 32'd4);

    // clamp 15 -> 11
    last_phase = 4'd15;
    tick(11);
    check("clamp_top", 32'(phase), 32'h800);
    tick();
    check("clamp_wrap", 32'(phase), 32'h001);
    check("clamp_done", 32'(instr_done), 32'h1);
    check("clamp_count", instr_count, 32'd5);

    // stall three cycles at idx 4
    last_phase = 4'd11;
    tick(4);
    check("stall_pre", 32'(phase), 32'h010);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold", 32'(phase), 32'h010);
      check("stall_idx", 32'(phase_idx), 32'd4);
    end
    stall = 1'b0;
    tick();
    check("stall_resume", 32'(phase), 32'h020);
    tick(6);
    check("stall_idx11", 32'(phase_idx), 32'd11);
    check("stall_nodone", 32'(instr_done), 32'h0);
    tick();
    check("stall_done", 32'(instr_done), 32'h1);
    check("stall_count", instr_count, 32'd6);

    // restart over stall at idx 7
    tick(7);
    check("rs_pre", 32'(phase), 32'h080);
    stall = 1'b1; restart = 1'b1;
    tick();
    stall = 1'b0; restart = 1'b0;
    check("rs_phase", 32'(phase), 32'h001);
    check("rs_nodone", 32'(instr_done), 32'h0);
    check("rs_count", instr_count, 32'd6);

    // run dropped at idx 3: instruction finishes, then IDLE
    tick(3);
    check("drop_pre", 32'(phase_idx), 32'd3);
    run = 1'b0;
    tick(8);
    check("drop_top", 32'(phase), 32'h800);
    check("drop_active", 32'(active), 32'h1);
    tick();
    check("drop_done", 32'(instr_done), 32'h1);
    check("drop_phase", 32'(phase), 32'h0);
    check("drop_idle", 32'(active), 32'h0);
    check("drop_count", instr_count, 32'd7);
    tick();
    check("idle_done", 32'(instr_done), 32'h0);
    check("idle_phase", 32'(phase), 32'h0);

    // reset mid-instruction at idx 9
    run = 1'b1;
    tick(10);
    check("mrst_pre", 32'(phase_idx), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    check("mrst_phase", 32'(phase), 32'h0);
    check("mrst_idx", 32'(phase_idx), 32'h0);
    check("mrst_active", 32'(active), 32'h0);
    check("mrst_done", 32'(instr_done), 32'h0);
    check("mrst_count", instr_count, 32'h0);

    // last_phase lowered below current index
    run = 1'b1;
    tick(7);
    check("low_pre", 32'(phase_idx), 32'd6);
    last_phase = 4'd3;
    tick();
    check("low_phase", 32'(phase), 32'h001);
    check("low_done", 32'(instr_done), 32'h1);
    check("low_count", instr_count, 32'd1);

    // one-phase instructions
    last_phase = 4'd0;
    tick();
    check("one_phase", 32'(phase), 32'h001);
    check("one_done", 32'(instr_done), 32'h1);
    tick();
    check("one_count", instr_count, 32'd3);

    // restart in IDLE with run=0
    run = 1'b0;
    tick();
    check("idle_enter", 32'(active), 32'h0);
    check("idle_count", instr_count, 32'd4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("idle_rs_phase", 32'(phase), 32'h0);
    check("idle_rs_active", 32'(active), 32'h0);

    // counter wrap on narrow instance
    run_w = 1'b1;
    tick();
    check("w_start", 32'(phase_w), 32'h1);
    check("w_count0", 32'(count_w), 32'd0);
    tick(7);
    check("w_count7", 32'(count_w), 32'd7);
    tick();
    check("w_wrap", 32'(count_w), 32'd0);
    check("w_done", 32'(done_w), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Parametrised successor to the fixed 12-phase CPU clock generator. Produces one-hot instruction phase strobes (fetch, decode, select, ALU, writeback, …) from a single clock. Adds per-instruction variable length, stall, abort/restart and a retired-instruction counter. Sits at the top of the datapath and drives every phase-enabled register, selector and ALU stage.

Parameters:
NUM_PHASES, 12, number of phase strobes per full-length instruction (legal 2..16)
CNT_W, 4, phase index width; 2^CNT_W >= NUM_PHASES required
CNT_INSTR_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = sequence instructions, 0 = stop after current instruction
stall  in  1  level; 1 = hold current phase (ACTIVE only)
restart  in  1  pulse; abort current instruction, return to phase 0 (jump/flush)
last_phase  in  CNT_W  index of final phase of current instruction (from decode num_of_ope mapping)
phase  out  NUM_PHASES  one-hot phase strobe; bit k = phase k+1 (clock_1 equivalent = bit 0)
phase_idx  out  CNT_W  binary index of active phase
active  out  1  1 while in ACTIVE state
instr_done  out  1  one-cycle pulse after an instruction completes normally
instr_count  out  CNT_INSTR_W  retired-instruction count

Behaviour:
- Reset (sync, active-high, highest priority): state IDLE; phase=0, phase_idx=0, active=0, instr_done=0, instr_count=0. Asserting reset mid-instruction yields these values the following cycle; no instr_done.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, ACTIVE.
- IDLE: phase all-zero. run=1 sampled -> next cycle ACTIVE, phase_idx=0, phase[0]=1. stall ignored in IDLE.
- ACTIVE, stall=0, not final: phase_idx+1; phase shifts left one bit.
- eff_last = min(last_phase, NUM_PHASES-1); last_phase compared live every cycle.
- Final phase: phase_idx >= eff_last (covers last_phase lowered below current index). On leaving it: instr_done=1 next cycle, instr_count+1 (wraps 2^CNT_INSTR_W-1 -> 0); run=1 -> phase_idx=0 same cycle (back-to-back, no bubble); run=0 -> IDLE.
- stall=1 in ACTIVE: phase/phase_idx held, including final phase; completion deferred until stall drops.
- restart=1: overrides stall and completion. Next cycle phase_idx=0 and ACTIVE if run=1, else IDLE. No instr_done, no count. Restart in IDLE with run=0 stays IDLE.
- Priority: reset > restart > stall > advance/complete.
- Invariant: phase one-hot in ACTIVE, zero in IDLE; phase[phase_idx]==1 when active.
- last_phase=0: one-phase instruction; completes every cycle while run=1.

Optional Feature:
CPU_PHASE_SINGLE_STEP_EN — adds inputs step_mode (level) and step (pulse) plus state STEP_WAIT. With macro and step_mode=1: after each completed instruction (instr_done pulses normally) enter STEP_WAIT, phase=0, active=0; step=1 -> next cycle ACTIVE phase 0; restart in STEP_WAIT -> IDLE if run=0; reset -> IDLE. step_mode=0 behaves as base. Without macro: ports and state absent; behaviour exactly as above.

Test Plan:
- Reset then run=1, last_phase=11, no stall -> phase = 0x001,0x002,…,0x800 over 12 cycles, then 0x001; instr_done pulses once per 12 cycles; instr_count=3 after 36 ACTIVE cycles.
- last_phase=5 -> 6-phase instructions, phase wraps 0x020->0x001; last_phase=15 clamps to 11.
- stall high 3 cycles at phase_idx=4 -> phase=0x010 held 4 cycles total; completion delayed 3 cycles; instr_count unaffected.
- restart at phase_idx=7 with stall=1 -> next cycle phase=0x001, no instr_done, count unchanged.
- run dropped at phase_idx=3 (last_phase=11) -> instruction finishes to idx 11, instr_done pulses, then IDLE, phase=0.
- reset at phase_idx=9 -> next cycle all outputs zero; preload instr_count to 0xFFFFFFFF via forced run -> completion wraps to 0.
